stack_xfer_ctrl: RTL and testbench

Sequencer for multi-beat 16-bit stack transfers of the 32-bit PC and 3-bit flags for CALL, RET, RTI and INT.
- Drives data-memory address, read and write strobes.
- Owns the stack pointer.
- Assembles popped words into pc_out and flags_out.
- Sits between decode/control and the data memory port and stalls the pipeline while a transfer runs.

---
 rtl/stack_xfer_if.sv | 53 +++++
 rtl/stack_xfer_ctrl.sv | 163 ++++++++++++++++
 tb/tb_stack_xfer_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/stack_xfer_if.sv
//------------------------------------------------------------------------------
// Module      : stack_xfer_if
// Description : Request, status and data-memory bundle for stack_xfer_ctrl.
//               STACK_GUARD_EN adds the stack_err status line.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface stack_xfer_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic [1:0]        op;
  logic [31:0]       pc_in;
  logic [2:0]        flags_in;
  logic [15:0]       mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [1:0]        beat;
  logic              stall;
  logic              busy;
  logic              done;
  logic [31:0]       pc_out;
  logic [2:0]        flags_out;
  logic              flags_load;
  logic [ADDR_W-1:0] sp_out;
`ifdef STACK_GUARD_EN
  logic              stack_err;
`endif

  // master: decode/control plus memory side; slave: the sequencer
  modport master (
    output start, op, pc_in, flags_in, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re, beat, stall, busy, done,
           pc_out, flags_out, flags_load, sp_out
`ifdef STACK_GUARD_EN
    , input stack_err
`endif
  );

  modport slave (
    input  start, op, pc_in, flags_in, mem_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re, beat, stall, busy, done,
           pc_out, flags_out, flags_load, sp_out
`ifdef STACK_GUARD_EN
    , output stack_err
`endif
  );
endinterface

`default_nettype wire

// File: rtl/stack_xfer_ctrl.sv
//------------------------------------------------------------------------------
// Module      : stack_xfer_ctrl
// Description : Multi-beat 16-bit stack sequencer for CALL/RET/RTI/INT.
//               Optional macro STACK_GUARD_EN enables overflow/underflow abort.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module stack_xfer_ctrl #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] SP_RESET = 12'hFFF,
  parameter logic [ADDR_W-1:0] SP_LIMIT = 12'h800
) (
  input  wire logic     clk,
  input  wire logic     rst,
  stack_xfer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0]        c_op_call = 2'b00;
  localparam logic [1:0]        c_op_rti  = 2'b10;
  localparam logic [1:0]        c_op_int  = 2'b11;
  localparam logic [ADDR_W-1:0] c_sp_one  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   c_ext_one = {{ADDR_W{1'b0}}, 1'b1};
`ifdef STACK_GUARD_EN
  localparam bit                c_guard   = 1'b1;
`else
  localparam bit                c_guard   = 1'b0;
`endif

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_sp;
  logic [1:0]        r_op;
  logic [1:0]        r_cnt;
  logic [31:0]       r_pc;
  logic [2:0]        r_flags;
  logic [15:0]       r_pc_lo;
  logic [2:0]        r_flags_pop;
  logic [31:0]       r_pc_out;
  logic [2:0]        r_flags_out;
  logic              r_err;

  logic              w_accept, w_req_push, w_push, w_abort;
  logic [1:0]        w_req_n;
  logic [ADDR_W:0]   w_sp_ext, w_n_ext;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [15:0]       w_mem_wdata;
  logic              w_mem_we, w_mem_re;

  // CALL(00) and INT(11) push; RET(01) and RTI(10) pop
  assign w_accept   = (r_state == ST_IDLE) && bus.start;
  assign w_req_push = ~(bus.op[1] ^ bus.op[0]);
  assign w_req_n    = bus.op[1] ? 2'd3 : 2'd2;
  assign w_push     = ~(r_op[1] ^ r_op[0]);

  // Bounds are checked one bit wider so neither side can wrap:
  // sp-(N-1) < LIMIT  <=>  sp+1 < LIMIT+N
  assign w_sp_ext = {1'b0, r_sp};
  assign w_n_ext  = {{(ADDR_W-1){1'b0}}, w_req_n};
  assign w_abort  = c_guard &&
                    (w_req_push ? ((w_sp_ext + c_ext_one) < ({1'b0, SP_LIMIT} + w_n_ext))
                                : ((w_sp_ext + w_n_ext) > {1'b0, SP_RESET}));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_abort ? ST_DONE : ST_XFER;
      ST_XFER: if (r_cnt == 2'd1) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Strobes are masked by rst so a reset edge never commits a beat
  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    if (r_state == ST_XFER) begin
      if (w_push) begin
        w_mem_addr = r_sp;
        w_mem_we   = ~rst;
        case (r_cnt)
          2'd3:    w_mem_wdata = r_pc[31:16];
          2'd2:    w_mem_wdata = (r_op == c_op_int) ? r_pc[15:0] : r_pc[31:16];
          2'd1:    w_mem_wdata = (r_op == c_op_int) ? {13'b0, r_flags} : r_pc[15:0];
          default: w_mem_wdata = '0;
        endcase
      end else begin
        w_mem_addr = r_sp + c_sp_one;
        w_mem_re   = ~rst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sp        <= SP_RESET;
      r_op        <= c_op_call;
      r_cnt       <= 2'd0;
      r_pc        <= '0;
      r_flags     <= '0;
      r_pc_lo     <= '0;
      r_flags_pop <= '0;
      r_pc_out    <= '0;
      r_flags_out <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op    <= bus.op;
        r_pc    <= bus.pc_in;
        r_flags <= bus.flags_in;
        r_cnt   <= w_abort ? 2'd0 : w_req_n;
        r_err   <= w_abort;
      end
      if (r_state == ST_XFER) begin
        r_cnt <= r_cnt - 2'd1;
        if (w_push) begin
          r_sp <= r_sp - c_sp_one;
        end else begin
          r_sp <= r_sp + c_sp_one;
          case (r_cnt)
            2'd3: r_flags_pop <= bus.mem_rdata[2:0];
            2'd2: r_pc_lo     <= bus.mem_rdata;
            2'd1: begin
              r_pc_out <= {bus.mem_rdata, r_pc_lo};
              if (r_op == c_op_rti) r_flags_out <= r_flags_pop;
            end
            default: ;
          endcase
        end
      end
      if (r_state == ST_DONE) r_err <= 1'b0;
    end
  end

  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_mem_wdata;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_re     = w_mem_re;
  assign bus.beat       = (r_state == ST_XFER) ? r_cnt : 2'd0;
  assign bus.busy       = (r_state == ST_XFER);
  assign bus.done       = (r_state == ST_DONE);
  assign bus.stall      = (r_state == ST_XFER) || w_accept || (r_state == ST_DONE);
  assign bus.flags_load = (r_state == ST_DONE) && (r_op == c_op_rti) && !r_err;
  assign bus.pc_out     = r_pc_out;
  assign bus.flags_out  = r_flags_out;
  assign bus.sp_out     = r_sp;
`ifdef STACK_GUARD_EN
  assign bus.stack_err  = (r_state == ST_DONE) && r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stack_xfer_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_stack_xfer_ctrl
// Description : Directed self-checking bench for stack_xfer_ctrl with a
//               behavioural 4K x 16 data memory. Honours STACK_GUARD_EN.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_stack_xfer_ctrl;

  localparam logic [1:0] OP_CALL = 2'b00;
  localparam logic [1:0] OP_RET  = 2'b01;
  localparam logic [1:0] OP_RTI  = 2'b10;
  localparam logic [1:0] OP_INT  = 2'b11;

  logic clk;
  logic rst;

  stack_xfer_if #(.ADDR_W(12)) bus ();

  stack_xfer_ctrl #(
    .ADDR_W  (12),
    .SP_RESET(12'hFFF),
    .SP_LIMIT(12'h800)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural memory: combinational read, write on posedge
  logic [15:0] mem [0:4095];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [15:0] pre_data;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_we)  mem[bus.mem_addr] <= bus.mem_wdata;
    else if (pre_we) mem[pre_addr]     <= pre_data;
  end

  int n_checks = 0;
  int n_errors = 0;

  // per-transfer observations gathered by run_xfer
  int          k_done, n_we, n_re, n_both, n_nostall, n_fl, n_err;
  logic [31:0] pc_before_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic preload(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // issue one request at cycle T and sample every cycle until done (bounded)
  task automatic run_xfer(input logic [1:0] op_v, input logic [31:0] pc_v,
                          input logic [2:0] fl_v, input bit hold, input string tag);
    bit seen;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = op_v;
    bus.pc_in    = pc_v;
    bus.flags_in = fl_v;
    #1;
    check({tag, "_stall_req"}, {31'b0, bus.stall}, 32'd1);
    k_done = 0; n_we = 0; n_re = 0; n_both = 0; n_nostall = 0; n_fl = 0; n_err = 0;
    pc_before_last = 32'hDEAD_DEAD;
    seen = 1'b0;
    while (!seen && k_done < 12) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      #1;
      k_done++;
      if (bus.mem_we) n_we++;
      if (bus.mem_re) n_re++;
      if (bus.mem_we && bus.mem_re) n_both++;
      if (!bus.stall) n_nostall++;
      if (bus.flags_load) n_fl++;
      if (bus.beat == 2'd1) pc_before_last = bus.pc_out;
`ifdef STACK_GUARD_EN
      if (bus.done && bus.stack_err) n_err++;
`endif
      if (bus.done) seen = 1'b1;
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.op       = 2'b00;
    bus.pc_in    = '0;
    bus.flags_in = '0;
    pre_we       = 1'b0;
    pre_addr     = '0;
    pre_data     = '0;

    apply_reset();
    #1;
    check("rst_sp",     {20'b0, bus.sp_out}, 32'h0000_0FFF);
    check("rst_busy",   {31'b0, bus.busy},   32'd0);
    check("rst_beat",   {30'b0, bus.beat},   32'd0);
    check("rst_stall",  {31'b0, bus.stall},  32'd0);
    check("rst_pc_out", bus.pc_out,          32'd0);
    check("rst_strobe", {30'b0, bus.mem_we, bus.mem_re}, 32'd0);

    // CALL 0001_2345 from FFF
    run_xfer(OP_CALL, 32'h0001_2345, 3'b000, 1'b0, "call");
    check("call_latency", k_done,    32'd3);
    check("call_writes",  n_we,      32'd2);
    check("call_stall",   n_nostall, 32'd0);
    check("call_sp",      {20'b0, bus.sp_out}, 32'h0000_0FFD);
    check("call_mem_fff", {16'b0, mem[12'hFFF]}, 32'h0000_0001);
    check("call_mem_ffe", {16'b0, mem[12'hFFE]}, 32'h0000_2345);
    @(negedge clk); #1;
    check("call_stall_off", {31'b0, bus.stall}, 32'd0);

    // RET pops the same PC back; pc_out stays old until the last beat
    run_xfer(OP_RET, 32'h0, 3'b000, 1'b0, "ret");
    check("ret_latency",  k_done,         32'd3);
    check("ret_reads",    n_re,           32'd2);
    check("ret_pc_early", pc_before_last, 32'h0000_0000);
    check("ret_pc_out",   bus.pc_out,     32'h0001_2345);
    check("ret_sp",       {20'b0, bus.sp_out}, 32'h0000_0FFF);
    check("ret_fl_load",  n_fl,           32'd0);

    // INT then RTI
    run_xfer(OP_INT, 32'h0000_00A0, 3'b101, 1'b0, "int");
    check("int_latency",  k_done, 32'd4);
    check("int_writes",   n_we,   32'd3);
    check("int_mem_fff",  {16'b0, mem[12'hFFF]}, 32'h0000_0000);
    check("int_mem_ffe",  {16'b0, mem[12'hFFE]}, 32'h0000_00A0);
    check("int_mem_ffd",  {16'b0, mem[12'hFFD]}, 32'h0000_0005);
    check("int_sp",       {20'b0, bus.sp_out},   32'h0000_0FFC);
    run_xfer(OP_RTI, 32'h0, 3'b000, 1'b0, "rti");
    check("rti_latency",  k_done,         32'd4);
    check("rti_reads",    n_re,           32'd3);
    check("rti_both",     n_both,         32'd0);
    check("rti_pc_early", pc_before_last, 32'h0001_2345);
    check("rti_pc_out",   bus.pc_out,     32'h0000_00A0);
    check("rti_flags",    {29'b0, bus.flags_out}, 32'd5);
    check("rti_fl_load",  n_fl,           32'd1);
    check("rti_sp",       {20'b0, bus.sp_out}, 32'h0000_0FFF);

    // start held high: one transfer, next accepted only after done
    run_xfer(OP_CALL, 32'h0001_2345, 3'b000, 1'b1, "hold");
    check("hold_latency", k_done, 32'd3);
    check("hold_writes",  n_we,   32'd2);
    @(negedge clk); #1;
    check("hold_idle_busy",  {31'b0, bus.busy},  32'd0);
    check("hold_idle_stall", {31'b0, bus.stall}, 32'd1);
    @(negedge clk); bus.start = 1'b0; #1;
    check("hold_2nd_busy", {31'b0, bus.busy}, 32'd1);
    check("hold_2nd_beat", {30'b0, bus.beat}, 32'd2);
    repeat (3) @(negedge clk);
    #1;
    check("hold_sp", {20'b0, bus.sp_out}, 32'h0000_0FFB);

    // reset during the second beat of INT
    apply_reset();
    preload(12'hFFF, 16'hFFFF);
    preload(12'hFFE, 16'hFFFF);
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_INT; bus.pc_in = 32'h0000_00A0; bus.flags_in = 3'b000;
    @(negedge clk); bus.start = 1'b0; #1;
    check("rstx_b1_addr", {20'b0, bus.mem_addr}, 32'h0000_0FFF);
    @(negedge clk); #1;
    check("rstx_b2_beat", {30'b0, bus.beat}, 32'd2);
    rst = 1'b1; #1;
    check("rstx_we_gated", {31'b0, bus.mem_we}, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    check("rstx_mem_fff", {16'b0, mem[12'hFFF]}, 32'h0000_0000);
    check("rstx_mem_ffe", {16'b0, mem[12'hFFE]}, 32'h0000_FFFF);
    check("rstx_sp",      {20'b0, bus.sp_out},   32'h0000_0FFF);
    check("rstx_outs",    {bus.busy, bus.done, bus.stall, bus.mem_we, bus.mem_re, bus.flags_load,
                           bus.beat, bus.flags_out, bus.mem_addr}, 32'd0);
    check("rstx_wdata",   {16'b0, bus.mem_wdata}, 32'd0);
    check("rstx_pc_out",  bus.pc_out, 32'd0);
    @(negedge clk); #1;
    check("rstx_mem_ffe_after", {16'b0, mem[12'hFFE]}, 32'h0000_FFFF);

    // establish a known pc_out, then pop from an empty stack
    run_xfer(OP_CALL, 32'hBEEF_0001, 3'b000, 1'b0, "call2");
    run_xfer(OP_RET,  32'h0,         3'b000, 1'b0, "ret2");
    check("ret2_pc_out", bus.pc_out, 32'hBEEF_0001);
`ifdef STACK_GUARD_EN
    run_xfer(OP_RET, 32'h0, 3'b000, 1'b0, "guard");
    check("guard_latency", k_done, 32'd1);
    check("guard_err",     n_err,  32'd1);
    check("guard_reads",   n_re,   32'd0);
    check("guard_sp",      {20'b0, bus.sp_out}, 32'h0000_0FFF);
    check("guard_pc_out",  bus.pc_out, 32'hBEEF_0001);
    @(negedge clk); #1;
    check("guard_err_clr", {31'b0, bus.stack_err}, 32'd0);
`else
    preload(12'h000, 16'h1111);
    preload(12'h001, 16'h2222);
    run_xfer(OP_RET, 32'h0, 3'b000, 1'b0, "wrap");
    check("wrap_latency", k_done, 32'd3);
    check("wrap_pc_out",  bus.pc_out, 32'h2222_1111);
    check("wrap_sp",      {20'b0, bus.sp_out}, 32'h0000_0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
